// File: rtl/snake_dir_ctrl.sv
// Direction input stage for the snake engine: sync, debounce, edge-detect, turn filtering and
// buffering. Define DIR_QUEUE_EN for a 2-entry turn FIFO; otherwise a single last-wins register.
module snake_dir_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int          CNT_W           = 20,
  parameter logic [3:0]  INIT_DIR        = 4'b1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       game_over,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [3:0] direction,
  output logic       turn,
  output logic [1:0] pend_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button bit positions coincide with the one-hot direction code: up, down, left, right.
  function automatic logic [3:0] opposite(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  function automatic logic is_legal(input logic [3:0] p, input logic [3:0] r);
    return (p != 4'b0000) && (p != r) && (p != opposite(r));
  endfunction

  function automatic logic [3:0] first_press(input logic [3:0] ev);
    logic [3:0] sel;
    sel = 4'b0000;
    if (ev[0])      sel = 4'b0001;
    else if (ev[1]) sel = 4'b0010;
    else if (ev[2]) sel = 4'b0100;
    else if (ev[3]) sel = 4'b1000;
    return sel;
  endfunction

  logic [3:0]       raw;
  logic [3:0]       sync_p0, sync_p1;
  logic [3:0]       db_p2, db_p3;
  logic [CNT_W-1:0] cnt_p2 [4];
  logic [3:0]       press_vld_p3;
  logic [3:0]       sel_p3;
  logic [3:0]       ref_dir;
  logic [3:0]       head;
  logic             has_pend;
  logic             accept;
  logic             pop;

  assign raw = {right, left, down, up};

  // p0/p1: two-flop synchroniser; p2: debounced state; p3: previous debounced state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      db_p2   <= '0;
      db_p3   <= '0;
      for (int i = 0; i < 4; i++) cnt_p2[i] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      db_p3   <= db_p2;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] != db_p2[i]) begin
          if (cnt_p2[i] == CNT_MAX) begin
            db_p2[i]  <= sync_p1[i];
            cnt_p2[i] <= '0;
          end else begin
            cnt_p2[i] <= cnt_p2[i] + 1'b1;
          end
        end else begin
          cnt_p2[i] <= '0;
        end
      end
    end
  end

  assign press_vld_p3 = db_p2 & ~db_p3;
  assign sel_p3       = first_press(press_vld_p3);
  assign accept       = !game_over && is_legal(sel_p3, ref_dir);
  assign pop          = tick && has_pend && !game_over;

`ifdef DIR_QUEUE_EN
  logic [3:0] fifo_q [2];
  logic [1:0] fill;

  assign ref_dir  = (fill == 2'd2) ? fifo_q[1] : (fill == 2'd1) ? fifo_q[0] : direction;
  assign head     = fifo_q[0];
  assign has_pend = (fill != 2'd0);
  assign pend_cnt = fill;

  // Pop is applied before push, so a full FIFO still takes a press on a commit cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill      <= 2'd0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (game_over) begin
      fill <= 2'd0;
    end else if (pop) begin
      if (accept) begin
        if (fill == 2'd2) begin
          fifo_q[0] <= fifo_q[1];
          fifo_q[1] <= sel_p3;
        end else begin
          fifo_q[0] <= sel_p3;
        end
      end else begin
        fifo_q[0] <= fifo_q[1];
        fill      <= fill - 2'd1;
      end
    end else if (accept) begin
      if (fill == 2'd0) begin
        fifo_q[0] <= sel_p3;
        fill      <= 2'd1;
      end else if (fill == 2'd1) begin
        fifo_q[1] <= sel_p3;
        fill      <= 2'd2;
      end
    end
  end
`else
  logic [3:0] pend;
  logic       pend_v;

  assign ref_dir  = (tick && pend_v) ? pend : direction;
  assign head     = pend;
  assign has_pend = pend_v;
  assign pend_cnt = {1'b0, pend_v};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend   <= '0;
      pend_v <= 1'b0;
    end else if (game_over) begin
      pend_v <= 1'b0;
    end else if (accept) begin
      pend   <= sel_p3;
      pend_v <= 1'b1;
    end else if (pop) begin
      pend_v <= 1'b0;
    end
  end
`endif

  // commit stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      direction <= INIT_DIR;
      turn      <= 1'b0;
    end else begin
      turn <= pop;
      if (pop) direction <= head;
    end
  end

endmodule
